// File: rtl/imem_fetch_loader.sv
// Instruction memory with a registered fetch port and a sequential burst loader.
// Fetch is locked out whenever the loader is active, so reads never collide with writes.
module imem_fetch_loader #(
  parameter int              AW        = 9,
  parameter int              DW        = 32,
  parameter logic [DW-1:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_req_i,
  input  logic [AW+1:0]   f_pc_i,
  input  logic            f_stall_i,
  output logic            f_valid_o,
  output logic [DW-1:0]   f_instr_o,
  output logic            f_misalign_o,
  input  logic            ld_start_i,
  input  logic [AW-1:0]   ld_base_i,
  input  logic [AW:0]     ld_len_i,
  input  logic            ld_valid_i,
  input  logic [DW-1:0]   ld_data_i,
  output logic            ld_ready_o,
  output logic            ld_busy_o,
  output logic            ld_done_o,
  output logic [AW:0]     ld_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] ONE_PTR = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_CNT = {{AW{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     count_q, count_d;
  logic            f_valid_q, f_valid_d;
  logic [DW-1:0]   f_instr_q, f_instr_d;
  logic            f_mis_q, f_mis_d;

  logic [DW-1:0]   mem_q [0:(1<<AW)-1];

  logic            start_acc_s;
  logic            wr_en_s;
  logic [AW:0]     count_inc_s;

  assign start_acc_s = (state_q == S_IDLE) && ld_start_i;
  assign wr_en_s     = (state_q == S_LOAD) && ld_valid_i;
  assign count_inc_s = count_q + ONE_CNT;

  // Loader next-state and pointer/count update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (ld_start_i) begin
          ptr_d   = ld_base_i;
          len_d   = ld_len_i;
          count_d = '0;
          state_d = (ld_len_i == '0) ? S_DONE : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (wr_en_s) begin
          ptr_d   = ptr_q + ONE_PTR;
          count_d = count_inc_s;
          state_d = (count_inc_s == len_q) ? S_DONE : S_LOAD;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch output next-state: lockout beats stall, stall beats a new request.
  always_comb begin
    f_valid_d = f_valid_q;
    f_instr_d = f_instr_q;
    f_mis_d   = f_mis_q;
    if ((state_q != S_IDLE) || start_acc_s) begin
      f_valid_d = 1'b0;
      f_mis_d   = 1'b0;
    end else if (f_stall_i) begin
      f_valid_d = f_valid_q;
    end else if (f_req_i) begin
      f_valid_d = 1'b1;
      if (f_pc_i[1:0] != 2'b00) begin
        f_instr_d = NOP_INSTR;
        f_mis_d   = 1'b1;
      end else begin
        f_instr_d = mem_q[f_pc_i[AW+1:2]];
        f_mis_d   = 1'b0;
      end
    end else begin
      f_valid_d = 1'b0;
      f_mis_d   = 1'b0;
    end
  end

  // State, pointer and fetch output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      count_q   <= '0;
      f_valid_q <= 1'b0;
      f_instr_q <= NOP_INSTR;
      f_mis_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      f_valid_q <= f_valid_d;
      f_instr_q <= f_instr_d;
      f_mis_q   <= f_mis_d;
    end
  end

  // Memory array is deliberately not reset so a reset mid-burst keeps written words.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[ptr_q] <= ld_data_i;
    end
  end

  assign f_valid_o    = f_valid_q;
  assign f_instr_o    = f_instr_q;
  assign f_misalign_o = f_mis_q;
  assign ld_ready_o   = (state_q == S_LOAD);
  assign ld_busy_o    = (state_q != S_IDLE);
  assign ld_done_o    = (state_q == S_DONE);
  assign ld_count_o   = count_q;

endmodule

// File: tb/tb_imem_fetch_loader.sv
// Self-checking bench: directed table, hand sequences and randomized traffic vs a memory model.
module tb_imem_fetch_loader;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, f_stall;
  logic [AW+1:0] f_pc;
  logic          f_valid, f_mis;
  logic [DW-1:0] f_instr;
  logic          ld_start, ld_valid;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic [DW-1:0] ld_data;
  logic          ld_ready, ld_busy, ld_done;
  logic [AW:0]   ld_count;

  imem_fetch_loader #(.AW(AW), .DW(DW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req), .f_pc_i(f_pc), .f_stall_i(f_stall),
    .f_valid_o(f_valid), .f_instr_o(f_instr), .f_misalign_o(f_mis),
    .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_len_i(ld_len),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready), .ld_busy_o(ld_busy), .ld_done_o(ld_done),
    .ld_count_o(ld_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: memory contents and the expected fetch outputs.
  logic [31:0] mm [0:(1<<AW)-1];
  bit          kn [0:(1<<AW)-1];
  int          kq [$];
  logic        ev;
  logic [31:0] ei;
  logic        em;

  typedef struct {
    logic        req;
    logic [10:0] pc;
    logic        st;
    logic        ev;
    logic [31:0] ei;
    logic        em;
  } fv_t;
  fv_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mwrite(input logic [AW-1:0] a, input logic [31:0] d);
    mm[a] = d;
    if (!kn[a]) begin
      kn[a] = 1'b1;
      kq.push_back(int'(a));
    end
  endtask

  task automatic do_fetch(input logic req, input logic [10:0] pc, input logic st);
    f_req = req; f_pc = pc; f_stall = st;
    tick();
    if (!st) begin
      if (req) begin
        ev = 1'b1;
        if (pc[1:0] != 2'b00) begin ei = NOP; em = 1'b1; end
        else begin ei = mm[pc[10:2]]; em = 1'b0; end
      end else begin
        ev = 1'b0;
      end
    end
    chk("f_valid", 64'(f_valid), 64'(ev));
    chk("f_instr", 64'(f_instr), 64'(ei));
    if (ev) chk("f_misalign", 64'(f_mis), 64'(em));
  endtask

  // vmode: 0 = valid every cycle, 1 = toggling 1,0,1,0.., 2 = random.
  task automatic load(input logic [AW-1:0] base, input logic [AW:0] len, input int vmode,
                      input bit rstart, input logic [31:0] seed);
    int sent, cyc;
    logic [AW-1:0] p;
    logic rdy, v;
    logic [31:0] d;
    sent = 0; cyc = 0; p = base;
    ld_start = 1'b1; ld_base = base; ld_len = len;
    f_req = 1'($urandom); f_stall = 1'($urandom); f_pc = 11'($urandom);
    tick();
    ld_start = 1'b0;
    ev = 1'b0;
    chk("f_valid_start_lock", 64'(f_valid), 64'd0);
    chk("ld_busy_start", 64'(ld_busy), 64'd1);
    chk("ld_count_clear", 64'(ld_count), 64'd0);
    if (len == '0) begin
      chk("ld_done_len0", 64'(ld_done), 64'd1);
      chk("ld_ready_len0", 64'(ld_ready), 64'd0);
    end else begin
      chk("ld_ready_first", 64'(ld_ready), 64'd1);
      while (1) begin
        if (cyc > 4 * int'(len) + 20) begin
          chk("load_timeout", 64'd0, 64'd1);
          break;
        end
        v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
        d = seed + 32'(sent);
        ld_valid = v; ld_data = d;
        ld_start = rstart ? 1'($urandom) : 1'b0;
        ld_base = 9'($urandom); ld_len = 10'($urandom);
        f_req = 1'($urandom); f_stall = 1'($urandom); f_pc = 11'($urandom);
        rdy = ld_ready;
        tick();
        cyc++;
        chk("f_valid_locked", 64'(f_valid), 64'd0);
        if (v && rdy) begin
          mwrite(p, d);
          p = p + 9'd1;
          sent++;
        end
        chk("ld_count", 64'(ld_count), 64'(sent));
        if (sent == int'(len)) begin
          chk("ld_done_pulse", 64'(ld_done), 64'd1);
          chk("ld_ready_done", 64'(ld_ready), 64'd0);
          break;
        end else begin
          chk("ld_done_early", 64'(ld_done), 64'd0);
          chk("ld_ready_load", 64'(ld_ready), 64'd1);
        end
      end
      if (vmode == 0) chk("burst_cycles", 64'(cyc), 64'(len));
    end
    ld_valid = 1'b0; ld_start = 1'b0; f_req = 1'b0; f_stall = 1'b0;
    tick();
    chk("ld_done_one_cycle", 64'(ld_done), 64'd0);
    chk("ld_busy_idle", 64'(ld_busy), 64'd0);
    chk("ld_count_hold", 64'(ld_count), 64'(len));
    chk("f_valid_after_load", 64'(f_valid), 64'd0);
    ev = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin mm[i] = '0; kn[i] = 1'b0; end
    rst = 1'b1; f_req = 1'b0; f_pc = '0; f_stall = 1'b0;
    ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    ev = 1'b0; ei = NOP; em = 1'b0;
    repeat (3) tick();
    chk("rst_f_valid", 64'(f_valid), 64'd0);
    chk("rst_f_instr", 64'(f_instr), 64'(NOP));
    chk("rst_f_misalign", 64'(f_mis), 64'd0);
    chk("rst_ld_busy", 64'(ld_busy), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_ld_done", 64'(ld_done), 64'd0);
    chk("rst_ld_count", 64'(ld_count), 64'd0);
    rst = 1'b0;
    tick();

    load(9'd0, 10'd4, 0, 1'b0, 32'hA0A0_0000);

    tbl[0]  = '{1'b1, 11'd0,  1'b0, 1'b1, 32'hA0A0_0000, 1'b0};
    tbl[1]  = '{1'b1, 11'd4,  1'b0, 1'b1, 32'hA0A0_0001, 1'b0};
    tbl[2]  = '{1'b1, 11'd8,  1'b0, 1'b1, 32'hA0A0_0002, 1'b0};
    tbl[3]  = '{1'b1, 11'd12, 1'b0, 1'b1, 32'hA0A0_0003, 1'b0};
    tbl[4]  = '{1'b1, 11'd6,  1'b0, 1'b1, NOP,           1'b1};
    tbl[5]  = '{1'b1, 11'd0,  1'b1, 1'b1, NOP,           1'b1};
    tbl[6]  = '{1'b0, 11'd8,  1'b1, 1'b1, NOP,           1'b1};
    tbl[7]  = '{1'b1, 11'd13, 1'b1, 1'b1, NOP,           1'b1};
    tbl[8]  = '{1'b0, 11'd4,  1'b0, 1'b0, NOP,           1'b0};
    tbl[9]  = '{1'b1, 11'd4,  1'b0, 1'b1, 32'hA0A0_0001, 1'b0};
    tbl[10] = '{1'b0, 11'd0,  1'b1, 1'b1, 32'hA0A0_0001, 1'b0};
    tbl[11] = '{1'b1, 11'd15, 1'b0, 1'b1, NOP,           1'b1};
    tbl[12] = '{1'b0, 11'd0,  1'b0, 1'b0, NOP,           1'b0};
    for (int i = 0; i < 13; i++) begin
      f_req = tbl[i].req; f_pc = tbl[i].pc; f_stall = tbl[i].st;
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(f_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_instr", i), 64'(f_instr), 64'(tbl[i].ei));
      if (tbl[i].ev) chk($sformatf("tbl%0d_mis", i), 64'(f_mis), 64'(tbl[i].em));
      ev = tbl[i].ev; ei = tbl[i].ei; em = tbl[i].em;
    end

    load(9'd20, 10'd3, 1, 1'b0, 32'hC0C0_0000);
    do_fetch(1'b1, 11'd80, 1'b0);
    do_fetch(1'b1, 11'd84, 1'b0);
    do_fetch(1'b1, 11'd88, 1'b0);
    chk("toggle_last_word", 64'(f_instr), 64'h0000_0000_C0C0_0002);

    load(9'd511, 10'd2, 0, 1'b0, 32'hB0B0_0000);
    do_fetch(1'b1, 11'h7FC, 1'b0);
    chk("wrap_first", 64'(f_instr), 64'h0000_0000_B0B0_0000);
    do_fetch(1'b1, 11'h000, 1'b0);
    chk("wrap_second", 64'(f_instr), 64'h0000_0000_B0B0_0001);

    load(9'd0, 10'd0, 0, 1'b0, 32'hDEAD_0000);
    do_fetch(1'b1, 11'h000, 1'b0);
    chk("len0_no_write", 64'(f_instr), 64'h0000_0000_B0B0_0001);

    for (int it = 0; it < 40; it++) begin
      if (($urandom % 4) == 0) begin
        load(9'($urandom), 10'($urandom_range(0, 8)), 2, 1'b1, $urandom);
      end else begin
        for (int k = 0; k < 10; k++) begin
          int a;
          logic [10:0] pc;
          a = kq[$urandom_range(0, kq.size() - 1)];
          pc = {9'(a), 2'b00};
          if (($urandom % 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
          do_fetch(($urandom % 4) != 0, pc, ($urandom % 4) == 0);
        end
      end
    end

    ld_start = 1'b1; ld_base = 9'd100; ld_len = 10'd5;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hE0E0_0000;
    tick();
    mwrite(9'd100, 32'hE0E0_0000);
    ld_data = 32'hE0E0_0001;
    tick();
    mwrite(9'd101, 32'hE0E0_0001);
    ld_valid = 1'b0;
    chk("mid_count_before_rst", 64'(ld_count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(ld_busy), 64'd0);
    chk("mid_rst_count", 64'(ld_count), 64'd0);
    chk("mid_rst_f_valid", 64'(f_valid), 64'd0);
    chk("mid_rst_ready", 64'(ld_ready), 64'd0);
    tick();
    rst = 1'b0;
    ev = 1'b0; ei = NOP; em = 1'b0;
    tick();
    do_fetch(1'b1, 11'd400, 1'b0);
    chk("mid_rst_word0", 64'(f_instr), 64'h0000_0000_E0E0_0000);
    do_fetch(1'b1, 11'd404, 1'b0);
    chk("mid_rst_word1", 64'(f_instr), 64'h0000_0000_E0E0_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
